// File: rtl/rv32_pkg.sv
// Shared types and defaults for the RV32 pipeline control logic.
// Holds the controller FSM states and the per-cycle hazard resolution helper.
package rv32_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        MEM_WAIT
    } ctrl_state_e;

    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_MEM_WAIT,
        ACT_BRANCH,
        ACT_LOAD_USE
    } ctrl_action_e;

    localparam int MEM_WAIT_MAX_DEFAULT = 255;

    // A memory wait freezes everything upstream, so it beats a redirect;
    // a redirect kills the stalled instruction, so it beats a load-use bubble.
    function automatic ctrl_action_e pick_action(logic mw, logic br, logic lu);
        ctrl_action_e act;
        if (mw) begin
            act = ACT_MEM_WAIT;
        end else if (br) begin
            act = ACT_BRANCH;
        end else if (lu) begin
            act = ACT_LOAD_USE;
        end else begin
            act = ACT_ADVANCE;
        end
        return act;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard requests into the pipeline controller and the enables, valids and
// performance counters it drives back to the datapath.
interface pipeline_ctrl_if;

    logic        load_use_stall_i;
    logic        branch_taken_i;
    logic        dmem_busy_i;

    logic        pc_en_o;
    logic        id_en_o;
    logic        ex_en_o;
    logic        mem_en_o;
    logic        wb_en_o;
    logic        pc_redirect_o;

    logic        id_valid_o;
    logic        ex_valid_o;
    logic        mem_valid_o;
    logic        wb_valid_o;

    logic [31:0] stall_cycles_o;
    logic [31:0] flush_count_o;
    logic        mem_timeout_o;

    modport master (
        input  load_use_stall_i, branch_taken_i, dmem_busy_i,
        output pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o, pc_redirect_o,
        output id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o,
        output stall_cycles_o, flush_count_o, mem_timeout_o
    );

    modport slave (
        output load_use_stall_i, branch_taken_i, dmem_busy_i,
        input  pc_en_o, id_en_o, ex_en_o, mem_en_o, wb_en_o, pc_redirect_o,
        input  id_valid_o, ex_valid_o, mem_valid_o, wb_valid_o,
        input  stall_cycles_o, flush_count_o, mem_timeout_o
    );

endinterface

// File: rtl/perf_counter.sv
// 32-bit wrapping event counter with synchronous clear.
module perf_counter (
    input  logic        clk,
    input  logic        srst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: resolves memory-wait, redirect and load-use
// hazards into register enables and per-stage valid bits.
module pipeline_ctrl #(
    parameter int MEM_WAIT_MAX = rv32_pkg::MEM_WAIT_MAX_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pipeline_ctrl_if.master ctrl
);
    import rv32_pkg::*;

    localparam logic [31:0] WAIT_MAX = 32'(MEM_WAIT_MAX);

    ctrl_state_e  state_reg, state_next;
    ctrl_action_e action;

    logic id_valid_reg, id_valid_next;
    logic ex_valid_reg, ex_valid_next;
    logic mem_valid_reg, mem_valid_next;
    logic wb_valid_reg, wb_valid_next;

    logic [31:0] wait_cnt_reg, wait_cnt_next;
    logic        mem_timeout_reg, mem_timeout_next;

    logic pc_en, id_en, ex_en, mem_en, wb_en, pc_redirect, flush_inc;
    logic lu, br, mw;

    // Raw requests only count when the stages they refer to hold live work.
    assign lu = ctrl.load_use_stall_i & id_valid_reg & ex_valid_reg;
    assign br = ctrl.branch_taken_i & ex_valid_reg;
    assign mw = ctrl.dmem_busy_i & mem_valid_reg;
    assign action = pick_action(mw, br, lu);

    always_comb begin
        state_next     = state_reg;
        id_valid_next  = id_valid_reg;
        ex_valid_next  = ex_valid_reg;
        mem_valid_next = mem_valid_reg;
        wb_valid_next  = wb_valid_reg;
        pc_en          = 1'b0;
        id_en          = 1'b0;
        ex_en          = 1'b0;
        mem_en         = 1'b0;
        wb_en          = 1'b0;
        pc_redirect    = 1'b0;
        flush_inc      = 1'b0;
        if (!rst_i) begin
            case (state_reg)
                BOOT: begin
                    {pc_en, id_en, ex_en, mem_en, wb_en} = 5'b11111;
                    id_valid_next  = 1'b0;
                    ex_valid_next  = id_valid_reg;
                    mem_valid_next = ex_valid_reg;
                    wb_valid_next  = mem_valid_reg;
                    state_next     = RUN;
                end
                default: begin
                    state_next = RUN;
                    case (action)
                        ACT_MEM_WAIT: begin
                            wb_en         = 1'b1;
                            wb_valid_next = 1'b0;
                            state_next    = MEM_WAIT;
                        end
                        ACT_BRANCH: begin
                            {pc_en, id_en, ex_en, mem_en, wb_en} = 5'b11111;
                            pc_redirect    = 1'b1;
                            flush_inc      = 1'b1;
                            id_valid_next  = 1'b0;
                            ex_valid_next  = 1'b0;
                            mem_valid_next = 1'b1;
                            wb_valid_next  = mem_valid_reg;
                        end
                        ACT_LOAD_USE: begin
                            {ex_en, mem_en, wb_en} = 3'b111;
                            ex_valid_next  = 1'b0;
                            mem_valid_next = ex_valid_reg;
                            wb_valid_next  = mem_valid_reg;
                        end
                        default: begin
                            {pc_en, id_en, ex_en, mem_en, wb_en} = 5'b11111;
                            id_valid_next  = 1'b1;
                            ex_valid_next  = id_valid_reg;
                            mem_valid_next = ex_valid_reg;
                            wb_valid_next  = mem_valid_reg;
                        end
                    endcase
                end
            endcase
        end
    end

    // Consecutive-wait counter saturates; the timeout flag is sticky and the
    // pipeline keeps waiting regardless.
    always_comb begin
        wait_cnt_next = '0;
        if (mw) begin
            wait_cnt_next = (wait_cnt_reg >= WAIT_MAX) ? WAIT_MAX : wait_cnt_reg + 32'd1;
        end
        mem_timeout_next = mem_timeout_reg | (mw && (wait_cnt_next == WAIT_MAX));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= BOOT;
            id_valid_reg    <= 1'b0;
            ex_valid_reg    <= 1'b0;
            mem_valid_reg   <= 1'b0;
            wb_valid_reg    <= 1'b0;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            id_valid_reg    <= id_valid_next;
            ex_valid_reg    <= ex_valid_next;
            mem_valid_reg   <= mem_valid_next;
            wb_valid_reg    <= wb_valid_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    logic [1:0]  cnt_inc;
    logic [31:0] cnt_val [2];

    assign cnt_inc[0] = ~rst_i & ~pc_en;
    assign cnt_inc[1] = flush_inc;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            perf_counter u_cnt (
                .clk   (clk_i),
                .srst  (rst_i),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign ctrl.pc_en_o        = pc_en;
    assign ctrl.id_en_o        = id_en;
    assign ctrl.ex_en_o        = ex_en;
    assign ctrl.mem_en_o       = mem_en;
    assign ctrl.wb_en_o        = wb_en;
    assign ctrl.pc_redirect_o  = pc_redirect;
    assign ctrl.id_valid_o     = id_valid_reg;
    assign ctrl.ex_valid_o     = ex_valid_reg;
    assign ctrl.mem_valid_o    = mem_valid_reg;
    assign ctrl.wb_valid_o     = wb_valid_reg;
    assign ctrl.stall_cycles_o = cnt_val[0];
    assign ctrl.flush_count_o  = cnt_val[1];
    assign ctrl.mem_timeout_o  = mem_timeout_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table from a full pipeline plus
// hand-written sequences for memory wait, timeout and reset corners.
module tb_pipeline_ctrl;
    import rv32_pkg::*;

    logic clk;
    logic srst;
    int   checks;
    int   failures;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.MEM_WAIT_MAX(4)) dut (
        .clk_i (clk),
        .rst_i (srst),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lu;
        logic        br;
        logic        busy;
        logic [4:0]  en;     // {pc, id, ex, mem, wb}
        logic        red;
        logic [3:0]  val;    // {id, ex, mem, wb} after the edge
        logic [31:0] stall;
        logic [31:0] flush;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lu, input logic br, input logic busy);
        bus.load_use_stall_i = lu;
        bus.branch_taken_i   = br;
        bus.dmem_busy_i      = busy;
    endtask

    function automatic logic [4:0] en_now();
        return {bus.pc_en_o, bus.id_en_o, bus.ex_en_o, bus.mem_en_o, bus.wb_en_o};
    endfunction

    function automatic logic [3:0] val_now();
        return {bus.id_valid_o, bus.ex_valid_o, bus.mem_valid_o, bus.wb_valid_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 4'b1111, 32'd0, 32'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 5'b00111, 1'b0, 4'b1011, 32'd1, 32'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 4'b1101, 32'd1, 32'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 5'b11111, 1'b1, 4'b0010, 32'd1, 32'd1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 5'b11111, 1'b0, 4'b1001, 32'd1, 32'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 5'b11111, 1'b0, 4'b1100, 32'd1, 32'd1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 4'b1110, 32'd1, 32'd1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 4'b1111, 32'd1, 32'd1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 5'b00001, 1'b0, 4'b1110, 32'd2, 32'd1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 5'b11111, 1'b0, 4'b1111, 32'd2, 32'd1};

        // Reset: enables held low, everything cleared.
        srst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #4;
        check("rst_en", 32'(en_now()), 32'd0);
        check("rst_redirect", 32'(bus.pc_redirect_o), 32'd0);
        check("rst_valids", 32'(val_now()), 32'd0);
        check("rst_stall", bus.stall_cycles_o, 32'd0);
        check("rst_flush", bus.flush_count_o, 32'd0);
        check("rst_timeout", 32'(bus.mem_timeout_o), 32'd0);
        check("rst_state", 32'(dut.state_reg), 32'(BOOT));

        // Release: BOOT cycle, then the pipeline fills one stage per cycle.
        tick();
        srst = 1'b0;
        #4;
        check("boot_en", 32'(en_now()), 32'h1f);
        tick();
        check("fill_e1", 32'(val_now()), 32'b0000);
        tick();
        check("fill_e2", 32'(val_now()), 32'b1000);
        tick();
        check("fill_e3", 32'(val_now()), 32'b1100);
        tick();
        check("fill_e4", 32'(val_now()), 32'b1110);
        tick();
        check("fill_e5", 32'(val_now()), 32'b1111);
        check("fill_stall", bus.stall_cycles_o, 32'd0);
        $display("seq fill done valids=%04b", val_now());

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].lu, vecs[i].br, vecs[i].busy);
            #4;
            check($sformatf("v%0d_en", i), 32'(en_now()), 32'(vecs[i].en));
            check($sformatf("v%0d_redirect", i), 32'(bus.pc_redirect_o), 32'(vecs[i].red));
            tick();
            check($sformatf("v%0d_valids", i), 32'(val_now()), 32'(vecs[i].val));
            check($sformatf("v%0d_stall", i), bus.stall_cycles_o, vecs[i].stall);
            check($sformatf("v%0d_flush", i), bus.flush_count_o, vecs[i].flush);
            $display("vec %0d lu=%0b br=%0b busy=%0b en=%05b valids=%04b", i,
                     vecs[i].lu, vecs[i].br, vecs[i].busy, en_now(), val_now());
        end

        // Memory wait of three cycles with a pending redirect held off.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            #4;
            check($sformatf("mw%0d_en", i), 32'(en_now()), 32'b00001);
            check($sformatf("mw%0d_redirect", i), 32'(bus.pc_redirect_o), 32'd0);
            tick();
            check($sformatf("mw%0d_valids", i), 32'(val_now()), 32'b1110);
        end
        check("mw_stall", bus.stall_cycles_o, 32'd5);
        drive(1'b0, 1'b1, 1'b0);
        #4;
        check("mw_rel_en", 32'(en_now()), 32'h1f);
        check("mw_rel_redirect", 32'(bus.pc_redirect_o), 32'd1);
        tick();
        check("mw_rel_valids", 32'(val_now()), 32'b0011);
        check("mw_rel_flush", bus.flush_count_o, 32'd2);
        check("mw_rel_stall", bus.stall_cycles_o, 32'd5);
        check("mw_rel_timeout", 32'(bus.mem_timeout_o), 32'd0);
        $display("seq mem_wait done stall=%0d flush=%0d", bus.stall_cycles_o, bus.flush_count_o);

        // Six busy cycles: timeout flag rises on the fourth and sticks.
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            tick();
            check($sformatf("to%0d_flag", i), 32'(bus.mem_timeout_o), (i >= 4) ? 32'd1 : 32'd0);
            check($sformatf("to%0d_valids", i), 32'(val_now()), 32'b0010);
        end
        check("to_stall", bus.stall_cycles_o, 32'd11);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("to_rel_valids", 32'(val_now()), 32'b1001);
        check("to_rel_flag", 32'(bus.mem_timeout_o), 32'd1);
        tick();
        tick();
        check("to_hold_valids", 32'(val_now()), 32'b1110);
        check("to_hold_flag", 32'(bus.mem_timeout_o), 32'd1);
        $display("seq timeout done flag=%0b", bus.mem_timeout_o);

        // Reset asserted in the middle of a memory wait.
        drive(1'b0, 1'b0, 1'b1);
        tick();
        check("rm_wait_stall", bus.stall_cycles_o, 32'd12);
        check("rm_wait_state", 32'(dut.state_reg), 32'(MEM_WAIT));
        srst = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        #4;
        check("rm_en", 32'(en_now()), 32'd0);
        check("rm_redirect", 32'(bus.pc_redirect_o), 32'd0);
        tick();
        check("rm_valids", 32'(val_now()), 32'd0);
        check("rm_stall", bus.stall_cycles_o, 32'd0);
        check("rm_flush", bus.flush_count_o, 32'd0);
        check("rm_timeout", 32'(bus.mem_timeout_o), 32'd0);
        check("rm_state", 32'(dut.state_reg), 32'(BOOT));
        srst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        #4;
        check("rm_boot_en", 32'(en_now()), 32'h1f);
        tick();
        check("rm_boot_valids", 32'(val_now()), 32'b0000);
        tick();
        check("rm_run_valids", 32'(val_now()), 32'b1000);
        $display("seq reset_mid_wait done valids=%04b", val_now());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
